// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/sub with valid/ready flow control and a tag sideband.
// Define PIPELINED_ADDER_FLAGS_EN to build the ovf/zero flag logic; otherwise those outputs read 0.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    logic [WIDTH-1:0]  a_q [STAGES], b_q [STAGES], r_q [STAGES];
    logic [WIDTH-1:0]  pa [STAGES], pb [STAGES], pr [STAGES];
    logic [TAG_W-1:0]  t_q [STAGES], pt [STAGES];
    logic [CHUNK:0]    s [STAGES];
    logic [STAGES-1:0] v_q, c_q, pv, pc, ld;

    // Operands shift down one chunk per stage; the result fills in from the top.
    always_comb begin
        logic acc;
        acc = out_ready;
        pa[0] = in_a;
        pb[0] = in_sub ? ~in_b : in_b;
        pr[0] = '0;
        pt[0] = in_tag;
        pv[0] = in_valid;
        pc[0] = in_cin ^ in_sub;
        for (int k = 1; k < STAGES; k++) begin
            pa[k] = a_q[k-1];
            pb[k] = b_q[k-1];
            pr[k] = r_q[k-1];
            pt[k] = t_q[k-1];
            pv[k] = v_q[k-1];
            pc[k] = c_q[k-1];
        end
        for (int k = L; k >= 0; k--) begin
            acc = acc | ~v_q[k];
            ld[k] = acc;
        end
        for (int k = 0; k < STAGES; k++)
            s[k] = {1'b0, pa[k][CHUNK-1:0]} + {1'b0, pb[k][CHUNK-1:0]} + {{CHUNK{1'b0}}, pc[k]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                t_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k])
                    v_q[k] <= pv[k];
                if (ld[k] && pv[k]) begin
                    a_q[k] <= pa[k] >> CHUNK;
                    b_q[k] <= pb[k] >> CHUNK;
                    r_q[k] <= (pr[k] >> CHUNK) | (WIDTH'(s[k][CHUNK-1:0]) << (WIDTH - CHUNK));
                    c_q[k] <= s[k][CHUNK];
                    t_q[k] <= pt[k];
                end
            end
        end
    end

`ifdef PIPELINED_ADDER_FLAGS_EN
    logic [STAGES-1:0] z_q, pz;
    logic              ovf_q, ovf_n;

    always_comb begin
        pz[0] = 1'b1;
        for (int k = 1; k < STAGES; k++)
            pz[k] = z_q[k-1];
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    assign ovf_n = s[L][CHUNK] ^ s[L][CHUNK-1] ^ pa[L][CHUNK-1] ^ pb[L][CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (ld[k] && pv[k])
                    z_q[k] <= pz[k] & ~|s[k][CHUNK-1:0];
            if (ld[L] && pv[L])
                ovf_q <= ovf_n;
        end
    end

    assign out_ovf  = ovf_q;
    assign out_zero = z_q[L];
`else
    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
`endif

    assign in_ready   = ld[0];
    assign out_valid  = v_q[L];
    assign out_result = r_q[L];
    assign out_cout   = c_q[L];
    assign out_tag    = t_q[L];
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder with an arithmetic reference model.
// Flag expectations follow PIPELINED_ADDER_FLAGS_EN.
module tb_pipelined_adder;
    localparam int W = 32, S = 4, T = 6;
`ifdef PIPELINED_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 0, rst_n = 0, in_valid = 0, in_cin = 0, in_sub = 0, out_ready = 1;
    logic in_ready, out_valid, out_cout, out_ovf, out_zero;
    logic [W-1:0] in_a = 0, in_b = 0, out_result;
    logic [T-1:0] in_tag = 0, out_tag;
    int checks = 0, failures = 0;
    bit rand_ready = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic c;
        logic v;
        logic z;
        logic [T-1:0] t;
    } res_t;
    res_t exp_q [$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    function automatic res_t model(input logic [W-1:0] a, b, input logic cin, sub, input logic [T-1:0] tag);
        longint ua = longint'(a), ub = longint'(b);
        longint sa = longint'($signed(a)), sb = longint'($signed(b));
        longint u, s;
        res_t e;
        u = sub ? ua - ub - longint'(cin) : ua + ub + longint'(cin);
        s = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
        e.r = u[W-1:0];
        e.c = sub ? (ua >= ub + longint'(cin)) : u[W];
        e.v = FLAGS && (s > 64'sd2147483647 || s < -64'sd2147483648);
        e.z = FLAGS && (e.r == 0);
        e.t = tag;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: compare the presented output with the oldest expectation every cycle it is valid,
    // so a stalled output that drifts is caught; pop only on an actual transfer.
    always @(negedge clk) begin : monitor
        res_t got;
        if (rst_n) begin
            if (out_valid) begin
                got = {out_result, out_cout, out_ovf, out_zero, out_tag};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h with no operation outstanding", got);
                end else begin
                    check("result", got, exp_q[0]);
                    if (out_ready)
                        void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready)
            out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] a, b, input logic cin, sub, input logic [T-1:0] tag, output int n);
        logic ok;
        in_valid = 1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        in_tag = tag;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corner [4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        int sel = int'($urandom_range(0, 7));
        return sel < 4 ? corner[sel] : W'($urandom);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, lat, seen;
        logic [W-1:0] bp_a, bp_b;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", out_result, 0);
        check("rst_flags", {out_cout, out_ovf, out_zero}, 0);
        check("rst_tag", out_tag, 0);
        rst_n = 1;

        send(32'hFFFFFFFF, 32'h1, 0, 0, 6'h15, n);
        check("first_accept_cycles", n, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        // Edges after the accepting edge: out_valid in the STAGES-th cycle counting the accept cycle.
        check("latency_edges", lat, S - 1);
        check("wrap_result", out_result, 0);
        check("wrap_cout", out_cout, 1);
        check("wrap_zero", out_zero, FLAGS);
        check("wrap_ovf", out_ovf, 0);
        check("wrap_tag", out_tag, 6'h15);
        tick();

        send(32'h7FFFFFFF, 32'h1, 0, 0, 6'h01, n);
        send(32'h80000000, 32'h1, 0, 1, 6'h02, n);
        send(32'h5, 32'h7, 0, 1, 6'h03, n);
        send(32'h7, 32'h5, 1, 1, 6'h04, n);
        send(32'h0, 32'h0, 0, 0, 6'h05, n);
        drain();

        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            send(W'($urandom), W'($urandom), 1'(i), i[0], 6'(10 + i), n);
            check("bp_accept_cycles", n, 1);
        end
        bp_a = W'($urandom);
        bp_b = W'($urandom);
        in_valid = 1;
        in_a = bp_a;
        in_b = bp_b;
        in_cin = 0;
        in_sub = 0;
        in_tag = 6'd14;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            tick();
        end
        out_ready = 1;
        send(bp_a, bp_b, 0, 0, 6'd14, n);
        check("bp_resume_cycles", n, 1);
        send(W'($urandom), W'($urandom), 1, 1, 6'd15, n);
        drain();

        for (int i = 0; i < 3; i++)
            send(W'($urandom), W'($urandom), 0, 0, 6'(20 + i), n);
        out_ready = 0;
        tick();
        check("pre_reset_valid", out_valid, 1);
        rst_n = 0;
        exp_q.delete();
        #1;
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_in_ready", in_ready, 1);
        check("mid_reset_result", out_result, 0);
        tick();
        tick();
        rst_n = 1;
        out_ready = 1;
        seen = 0;
        repeat (10) begin
            tick();
            seen += int'(out_valid);
        end
        check("no_stale_after_reset", seen, 0);

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                tick();
            else
                send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), T'($urandom), n);
        end
        rand_ready = 0;
        out_ready = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined integer add/subtract unit for the execution datapath; the registered, flow-controlled successor to the 32-bit combinational adder. The carry chain is split into STAGES equal chunks, one chunk per pipeline stage, so wide adds close timing at core clock. Valid/ready handshakes on both sides give per-stage bubble collapsing, and an opaque tag travels with each operation for writeback routing.

## Interface
- WIDTH, 32: operand/result width; must be divisible by STAGES.
- STAGES, 4: pipeline depth, 1..8; CHUNK = WIDTH/STAGES bits per stage.
- TAG_W, 6: sideband tag width, ≥1.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit accepts input this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add) / borrow-in (sub).
- in_sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  sum/difference mod 2^WIDTH.
- out_cout  out  1  carry-out; for sub, 1 = no borrow.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_result == 0.
- out_tag  out  TAG_W  tag of this result.

## Operation
- Sub is A + ~B + !cin; the stage-0 carry-in is in_cin ^ in_sub and B is inverted on entry.
- Stage k (0..STAGES−1) adds bits [k*CHUNK +: CHUNK] with the carry registered by stage k−1.
- Lower result chunks and the unconsumed upper operand chunks are registered forward with the operation, so each operation needs no re-read of inputs.
- The zero flag accumulates per stage as the AND of chunk-zero terms.
- Overflow = carry into MSB XOR carry out of MSB, computed in the last stage.
- Each stage has a valid bit. Stage k loads when it is empty or stage k+1 (or the output for the last stage) takes its contents this cycle.
- in_ready = stage-0 load condition; it is combinational from out_ready through the stage valids.
- Transfer occurs on valid && ready at either port. Order is strictly preserved, with no drop or duplication.
- Output holds stable (result, flags, tag) while out_valid && !out_ready.
- STAGES = 1 degenerates to a single registered add with a skid-free handshake.

## Timing
- Latency: STAGES cycles from input acceptance to out_valid when unstalled.
- Throughput: 1 operation/cycle with out_ready held high.
- Capacity: STAGES operations in flight. in_ready falls only when every stage is full and out_ready is low.
- Simultaneous accept and output in the same cycle with a full pipe is legal and sustains full rate.
- Reset (asynchronous assert, any time including mid-operation): all stage valids go to 0 and all data/flag/tag registers go to 0. Outputs read out_valid=0, result/flags/tag=0, in_ready=1 after reset. In-flight operations are discarded.
- Reset deassertion: the first input is accepted on the first rising edge with rst_n high.

## Configuration
- PIPELINED_ADDER_FLAGS_EN defined: out_cout, out_ovf and out_zero are computed as above, and their per-stage zero/carry registers are present.
- Not defined: the flag logic and its registers are omitted. out_ovf and out_zero are tied to 0. out_cout is still produced, because the carry chain needs it.
- The ports exist in both builds.

## Test plan
All cases use WIDTH=32, STAGES=4, TAG_W=6, flags macro defined unless stated.
- 0xFFFFFFFF + 0x00000001, cin=0, tag=0x15 -> 4 cycles later: result 0x00000000, cout=1, zero=1, ovf=0, tag 0x15.
- 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf=1, cout=0, zero=0. Sub 0x80000000 − 1 -> 0x7FFFFFFF, ovf=1, cout=1.
- Sub 5 − 7, cin=0 -> 0xFFFFFFFE, cout=0, ovf=0. Sub 7 − 5, cin=1 -> 0x00000001, cout=1.
- Backpressure: 6 back-to-back inputs with out_ready low for cycles 3..8. in_ready drops after exactly 4 are held. All 6 results appear in order with correct tags, and each output is stable while stalled.
- Assert rst_n low with 3 operations in flight -> out_valid=0 and in_ready=1 immediately. No stale result appears after release.
- Macro undefined: 0xFFFFFFFF + 1 -> result 0, cout=1, zero=0, ovf=0.
